// File: rtl/enemy_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : enemy_sequencer
// Purpose  : Per-move erase / coordinate update / redraw sequencer for the
//            enemy sprite datapath, with request/grant VGA port arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_sequencer #(
  parameter int N_ENEMY         = 10,
  parameter int SPRITE_PIX      = 25,
  parameter int FRAMES_PER_MOVE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       frame_tick,
  input  logic       vga_grant,
  input  logic       update_ack,
  output logic       vga_req,
  output logic       enable,
  output logic       plot,
  output logic [1:0] op,
  output logic       load_coord,
  output logic       update_req,
  output logic       busy,
  output logic       pass_done,
  output logic       overrun
);

  localparam logic [8:0] PIX_LAST   = 9'(N_ENEMY * SPRITE_PIX - 1);
  localparam logic [3:0] FRAME_LAST = 4'(FRAMES_PER_MOVE - 1);

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WAIT  = 4'd1;
  localparam logic [3:0] S_REQ_E = 4'd2;
  localparam logic [3:0] S_ERASE = 4'd3;
  localparam logic [3:0] S_UPD   = 4'd4;
  localparam logic [3:0] S_LOAD  = 4'd5;
  localparam logic [3:0] S_REQ_D = 4'd6;
  localparam logic [3:0] S_DRAW  = 4'd7;
  localparam logic [3:0] S_FIN   = 4'd8;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [8:0] pix_cnt;
  logic [3:0] frame_cnt;
  logic       move_due;

  logic scanning;   // in a pixel-scanning phase (erase or draw)
  logic last_pix;   // current granted cycle issues the final pixel of a phase
  logic due_now;    // a frame tick completes a movement period this cycle
  logic consume;    // WAIT takes the pending move this cycle

  assign scanning = (state == S_ERASE) || (state == S_DRAW);
  assign last_pix = vga_grant && (pix_cnt == PIX_LAST);
  assign due_now  = (state != S_IDLE) && frame_tick && (frame_cnt == FRAME_LAST);
  assign consume  = (state == S_WAIT) && run && move_due;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (run) state_next = S_WAIT;
      S_WAIT: begin
        if (!run)         state_next = S_IDLE;
        else if (move_due) state_next = S_REQ_E;
      end
      S_REQ_E: if (vga_grant) state_next = S_ERASE;
      S_ERASE: if (last_pix) state_next = S_UPD;
      S_UPD:   if (update_ack) state_next = S_LOAD;
      S_LOAD:  state_next = S_REQ_D;
      S_REQ_D: if (vga_grant) state_next = S_DRAW;
      S_DRAW:  if (last_pix) state_next = S_FIN;
      S_FIN:   state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore output decode; only enable/plot see the live grant
  always_comb begin
    vga_req    = 1'b0;
    op         = OP_ERASE;
    load_coord = 1'b0;
    update_req = 1'b0;
    busy       = 1'b1;
    pass_done  = 1'b0;
    case (state)
      S_IDLE, S_WAIT:   busy = 1'b0;
      S_REQ_E, S_ERASE: vga_req = 1'b1;
      S_UPD:            update_req = 1'b1;
      S_LOAD: begin
        op         = OP_DRAW;
        load_coord = 1'b1;
      end
      S_REQ_D, S_DRAW: begin
        op      = OP_DRAW;
        vga_req = 1'b1;
      end
      S_FIN: begin
        op        = OP_DRAW;
        pass_done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
    enable = scanning && vga_grant;
    plot   = enable;
  end

  // Pixel counter, frame counter and the one-deep pending-move flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt   <= 9'd0;
      frame_cnt <= 4'd0;
      move_due  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // The request state always precedes a scan phase, so clearing there
      // starts every phase from pixel 0; a withdrawn grant holds the count.
      if ((state == S_REQ_E) || (state == S_REQ_D)) begin
        pix_cnt <= 9'd0;
      end else if (scanning && vga_grant && (pix_cnt != PIX_LAST)) begin
        pix_cnt <= pix_cnt + 9'd1;
      end

      if ((state != S_IDLE) && frame_tick) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? 4'd0 : frame_cnt + 4'd1;
      end

      // A move landing on the consume cycle simply re-arms the flag.
      if (due_now) begin
        move_due <= 1'b1;
        if (move_due && !consume) begin
          overrun <= 1'b1;
        end
      end else if (consume) begin
        move_due <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enemy_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_enemy_sequencer
// Purpose  : Scoreboard bench for enemy_sequencer (default and 1-frame move).
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, frame_tick, vga_grant, update_ack;
  logic       vga_req, enable, plot, load_coord, update_req, busy, pass_done, overrun;
  logic [1:0] op;

  logic       run_1, frame_tick_1, vga_grant_1, update_ack_1;
  logic       vga_req_1, enable_1, plot_1, load_coord_1, update_req_1, busy_1, pass_done_1, overrun_1;
  logic [1:0] op_1;

  enemy_sequencer #(.N_ENEMY(10), .SPRITE_PIX(25), .FRAMES_PER_MOVE(4)) dut (
    .clk(clk), .reset(rst), .run(run), .frame_tick(frame_tick), .vga_grant(vga_grant),
    .update_ack(update_ack), .vga_req(vga_req), .enable(enable), .plot(plot), .op(op),
    .load_coord(load_coord), .update_req(update_req), .busy(busy), .pass_done(pass_done),
    .overrun(overrun)
  );

  enemy_sequencer #(.N_ENEMY(10), .SPRITE_PIX(25), .FRAMES_PER_MOVE(1)) dut1 (
    .clk(clk), .reset(rst), .run(run_1), .frame_tick(frame_tick_1), .vga_grant(vga_grant_1),
    .update_ack(update_ack_1), .vga_req(vga_req_1), .enable(enable_1), .plot(plot_1), .op(op_1),
    .load_coord(load_coord_1), .update_req(update_req_1), .busy(busy_1), .pass_done(pass_done_1),
    .overrun(overrun_1)
  );

  typedef struct {
    int erase_en;
    int draw_en;
    int loads;
    int upd_len;
    int erase_span;
  } pass_exp_t;

  pass_exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int er_cnt = 0, dr_cnt = 0, er_first = 0, er_last = 0, upd_len = 0, loads = 0;
  int passes_seen = 0;
  int ack_delay = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_pass(input int upd, input int span);
    pass_exp_t e;
    e.erase_en = 250; e.draw_en = 250; e.loads = 1; e.upd_len = upd; e.erase_span = span;
    exp_q.push_back(e);
  endtask

  task automatic do_move();
    repeat (4) begin
      frame_tick = 1'b1; step(1);
      frame_tick = 1'b0; step(1);
    end
  endtask

  task automatic wait_pass(input int target, input string name);
    int b;
    b = 0;
    while (passes_seen < target && b < 3000) begin
      step(1);
      b++;
    end
    check(name, int'(passes_seen >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vga_req"},    int'(vga_req), 0);
    check({tag, "_enable"},     int'(enable), 0);
    check({tag, "_plot"},       int'(plot), 0);
    check({tag, "_load_coord"}, int'(load_coord), 0);
    check({tag, "_update_req"}, int'(update_req), 0);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_pass_done"},  int'(pass_done), 0);
    check({tag, "_op"},         int'(op), 1);
    check({tag, "_overrun"},    int'(overrun), 0);
  endtask

  // Monitor: tallies per-pass activity and scores it against the queue on pass_done
  initial begin
    pass_exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        er_cnt = 0; dr_cnt = 0; upd_len = 0; loads = 0;
      end else begin
        if (enable || plot) begin
          check("plot_eq_enable", int'(plot), int'(enable));
          if (op == 2'b01) begin
            if (er_cnt == 0) er_first = cyc;
            er_last = cyc;
            er_cnt++;
          end else begin
            dr_cnt++;
          end
        end
        if (update_req) upd_len++;
        if (load_coord) loads++;
        if (pass_done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pass_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("erase_enables", er_cnt, e.erase_en);
            check("draw_enables",  dr_cnt, e.draw_en);
            check("load_pulses",   loads, e.loads);
            check("update_req_len", upd_len, e.upd_len);
            check("erase_span",    er_last - er_first + 1, e.erase_span);
          end
          er_cnt = 0; dr_cnt = 0; upd_len = 0; loads = 0;
          passes_seen++;
        end
      end
    end
  end

  // Position-updater model: acks ack_delay cycles after seeing update_req
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (update_req && !rst) begin
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge clk);
          #2;
        end
        update_ack = 1'b1;
        @(posedge clk);
        #2;
        update_ack = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int any_req;
    int b;
    int n1;
    rst = 1'b1; run = 1'b0; frame_tick = 1'b0; vga_grant = 1'b1; update_ack = 1'b0;
    run_1 = 1'b0; frame_tick_1 = 1'b0; vga_grant_1 = 1'b0; update_ack_1 = 1'b0;
    step(3);
    check_reset_outputs("por");
    rst = 1'b0;
    step(1);

    // Idle to WAIT
    run = 1'b1;
    step(2);
    check("wait_busy", int'(busy), 0);
    check("wait_vga_req", int'(vga_req), 0);

    // Pass A: grant tied high, ack in first UPD cycle
    push_pass(1, 250);
    do_move();
    wait_pass(1, "passA_timeout");

    // Pass B: grant withdrawn for 7 cycles at erase count 120
    push_pass(1, 257);
    do_move();
    b = 0;
    while (er_cnt < 120 && b < 1000) begin step(1); b++; end
    check("passB_reach120", int'(er_cnt >= 120), 1);
    vga_grant = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("gap_enable", int'(enable), 0);
      check("gap_vga_req", int'(vga_req), 1);
      check("gap_count_hold", int'(dut.pix_cnt), 120);
      @(posedge clk);
      #2;
    end
    vga_grant = 1'b1;
    wait_pass(2, "passB_timeout");

    // Spurious ack in WAIT, then pass C with a 30-cycle ack delay
    step(2);
    update_ack = 1'b1; step(1); update_ack = 1'b0;
    @(negedge clk);
    check("spurious_load", int'(load_coord), 0);
    check("spurious_busy", int'(busy), 0);
    step(1);
    ack_delay = 30;
    push_pass(31, 250);
    do_move();
    wait_pass(3, "passC_timeout");
    ack_delay = 0;

    // Pass D: run dropped during ERASE, pass still completes
    push_pass(1, 250);
    do_move();
    b = 0;
    while (er_cnt < 10 && b < 1000) begin step(1); b++; end
    run = 1'b0;
    wait_pass(4, "passD_timeout");
    step(2);
    check("run_off_busy", int'(busy), 0);
    any_req = 0;
    repeat (8) begin
      frame_tick = 1'b1; step(1);
      if (vga_req) any_req = 1;
      frame_tick = 1'b0; step(1);
      if (vga_req) any_req = 1;
    end
    check("run_off_no_req", any_req, 0);

    // Reset mid-DRAW at pixel count 100
    run = 1'b1;
    step(2);
    push_pass(1, 250);
    do_move();
    b = 0;
    while (dr_cnt < 100 && b < 1000) begin step(1); b++; end
    check("draw_reach100", int'(dr_cnt >= 100), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    step(2);
    rst = 1'b0;
    push_pass(1, 250);
    step(2);
    repeat (3) begin
      frame_tick = 1'b1; step(1);
      frame_tick = 1'b0; step(1);
    end
    @(negedge clk);
    check("req_after_3_ticks", int'(vga_req), 0);
    step(1);
    frame_tick = 1'b1;
    @(negedge clk);
    check("req_in_4th_tick", int'(vga_req), 0);
    step(1);
    frame_tick = 1'b0;
    step(1);
    @(negedge clk);
    check("req_after_4th_tick", int'(vga_req), 1);
    wait_pass(passes_seen + 1, "post_reset_pass_timeout");

    // FRAMES_PER_MOVE=1: tick on consume cycle re-arms, third tick overruns
    run_1 = 1'b1;
    step(2);
    frame_tick_1 = 1'b1;
    step(2);
    frame_tick_1 = 1'b0;
    @(negedge clk);
    check("fpm1_no_overrun", int'(overrun_1), 0);
    check("fpm1_req", int'(vga_req_1), 1);
    step(1);
    frame_tick_1 = 1'b1;
    step(1);
    frame_tick_1 = 1'b0;
    @(negedge clk);
    check("fpm1_overrun", int'(overrun_1), 1);
    step(1);
    vga_grant_1 = 1'b1;
    n1 = 0;
    for (int i = 0; i < 2500; i++) begin
      step(1);
      update_ack_1 = update_req_1;
      if (pass_done_1) n1++;
    end
    check("fpm1_pass_count", n1, 2);
    check("fpm1_overrun_sticky", int'(overrun_1), 1);
    check("fpm1_idle_busy", int'(busy_1), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
